// File: rtl/lfsr_test_ctrl.sv
// lfsr_test_ctrl: stimulus sequencer for the LFSR generator/checker pair.
//
// Runs one scripted self-test per accepted start request: soft-reset the pair
// with a seed, wait for lock, hold lock for RUN_CYCLES, force corruption until
// lock drops, then wait for re-lock. Reports pass/fail, the state where a
// failure happened, and the three measured latencies.
//
// Optional feature macro: LFSR_TEST_PAUSE_EN (adds i_pause, which freezes the
// wait states and drops o_valid while high).
//
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_start        start-test request (sampled in IDLE only)
//   i_seed         requested seed (0 selects DEF_SEED)
//   i_lock         lock flag from the checker
//   i_pause        (LFSR_TEST_PAUSE_EN only) stall the wait states
//   o_seed         seed presented to the pair
//   o_soft_reset   one-cycle reset pulse to the pair
//   o_valid        LFSR advance enable
//   o_corrupt      corrupt-data control
//   o_busy         high in every state except IDLE
//   o_done         one-cycle pulse in PASS or FAIL
//   o_pass         result of the last completed test
//   o_fail_code    state in which the test failed (0 on pass)
//   o_lock_lat     cycles from WAIT_LOCK entry to first lock
//   o_unlock_lat   cycles from CORRUPT entry to first loss of lock
//   o_relock_lat   cycles from RECOVER entry to first lock

module lfsr_test_ctrl #(
    parameter logic [15:0] DEF_SEED   = 16'd300,
    parameter int unsigned RUN_CYCLES = 32,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [15:0]      i_seed,
    input  logic             i_lock,
`ifdef LFSR_TEST_PAUSE_EN
    input  logic             i_pause,
`endif
    output logic [15:0]      o_seed,
    output logic             o_soft_reset,
    output logic             o_valid,
    output logic             o_corrupt,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [2:0]       o_fail_code,
    output logic [CNT_W-1:0] o_lock_lat,
    output logic [CNT_W-1:0] o_unlock_lat,
    output logic [CNT_W-1:0] o_relock_lat
);

    // Encoding is visible externally through o_fail_code.
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StSeed     = 3'd1,
        StWaitLock = 3'd2,
        StRun      = 3'd3,
        StCorrupt  = 3'd4,
        StRecover  = 3'd5,
        StPass     = 3'd6,
        StFail     = 3'd7
    } state_e;

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RunLast     = CNT_W'(RUN_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;

    logic [15:0]      r_seed;
    logic             r_pass;
    logic [2:0]       r_fail_code;
    logic [CNT_W-1:0] r_lock_lat;
    logic [CNT_W-1:0] r_unlock_lat;
    logic [CNT_W-1:0] r_relock_lat;

    logic w_pause;
    logic w_wait_state;
    logic w_hold;
    logic w_start_acc;
    logic w_lock_we;
    logic w_unlock_we;
    logic w_relock_we;
    logic w_to_pass;
    logic w_to_fail;

`ifdef LFSR_TEST_PAUSE_EN
    assign w_pause = i_pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_wait_state = (r_state == StWaitLock) || (r_state == StRun) ||
                          (r_state == StCorrupt)  || (r_state == StRecover);
    // A paused wait state neither advances its counter nor evaluates exits.
    assign w_hold       = w_wait_state && w_pause;

    // Saturating increment: the counter never wraps.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_start_acc  = 1'b0;
        w_lock_we    = 1'b0;
        w_unlock_we  = 1'b0;
        w_relock_we  = 1'b0;
        w_to_pass    = 1'b0;
        w_to_fail    = 1'b0;

        if (!w_hold) begin
            unique case (r_state)
                StIdle: begin
                    w_cnt_next = '0;
                    if (i_start) begin
                        w_state_next = StSeed;
                        w_start_acc  = 1'b1;
                    end
                end
                StSeed: begin
                    w_state_next = StWaitLock;
                    w_cnt_next   = '0;
                end
                // Events are checked before the timeout so they win a tie.
                StWaitLock: begin
                    if (i_lock) begin
                        w_lock_we    = 1'b1;
                        w_state_next = StRun;
                        w_cnt_next   = '0;
                    end else if (r_cnt == TimeoutLast) begin
                        w_to_fail    = 1'b1;
                    end else begin
                        w_cnt_next   = w_cnt_inc;
                    end
                end
                StRun: begin
                    if (!i_lock) begin
                        w_to_fail    = 1'b1;
                    end else if (r_cnt == RunLast) begin
                        w_state_next = StCorrupt;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = w_cnt_inc;
                    end
                end
                StCorrupt: begin
                    if (!i_lock) begin
                        w_unlock_we  = 1'b1;
                        w_state_next = StRecover;
                        w_cnt_next   = '0;
                    end else if (r_cnt == TimeoutLast) begin
                        w_to_fail    = 1'b1;
                    end else begin
                        w_cnt_next   = w_cnt_inc;
                    end
                end
                StRecover: begin
                    if (i_lock) begin
                        w_relock_we  = 1'b1;
                        w_to_pass    = 1'b1;
                    end else if (r_cnt == TimeoutLast) begin
                        w_to_fail    = 1'b1;
                    end else begin
                        w_cnt_next   = w_cnt_inc;
                    end
                end
                StPass, StFail: begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end
                default: begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end
            endcase

            if (w_to_pass) begin
                w_state_next = StPass;
                w_cnt_next   = '0;
            end
            if (w_to_fail) begin
                w_state_next = StFail;
                w_cnt_next   = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_seed       <= DEF_SEED;
            r_pass       <= 1'b0;
            r_fail_code  <= 3'd0;
            r_lock_lat   <= '0;
            r_unlock_lat <= '0;
            r_relock_lat <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;

            if (w_start_acc) begin
                r_seed       <= (i_seed == 16'd0) ? DEF_SEED : i_seed;
                r_pass       <= 1'b0;
                r_fail_code  <= 3'd0;
                r_lock_lat   <= '0;
                r_unlock_lat <= '0;
                r_relock_lat <= '0;
            end
            if (w_lock_we) begin
                r_lock_lat <= r_cnt;
            end
            if (w_unlock_we) begin
                r_unlock_lat <= r_cnt;
            end
            if (w_relock_we) begin
                r_relock_lat <= r_cnt;
            end
            // Results are latched on the transition so they are already valid
            // during the PASS/FAIL cycle that carries o_done.
            if (w_to_pass) begin
                r_pass      <= 1'b1;
                r_fail_code <= 3'd0;
            end
            if (w_to_fail) begin
                r_pass      <= 1'b0;
                r_fail_code <= r_state;
            end
        end
    end

    assign o_seed       = r_seed;
    assign o_soft_reset = (r_state == StSeed);
    assign o_valid      = w_wait_state && !w_pause;
    assign o_corrupt    = (r_state == StCorrupt);
    assign o_busy       = (r_state != StIdle);
    assign o_done       = (r_state == StPass) || (r_state == StFail);
    assign o_pass       = r_pass;
    assign o_fail_code  = r_fail_code;
    assign o_lock_lat   = r_lock_lat;
    assign o_unlock_lat = r_unlock_lat;
    assign o_relock_lat = r_relock_lat;

endmodule
